// File: rtl/disk_pkg.sv
// Shared types and helpers for the multi-drive track loader.
package disk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } dtl_state_e;

  localparam int NIB_SECS_PER_TRACK = 13;

  function automatic logic [31:0] lba_of_track(input logic [31:0] trk, input int spt);
    lba_of_track = trk * 32'(spt);
  endfunction

endpackage

// File: rtl/dtl_prio_pick.sv
// Fixed-priority picker: returns the lowest index with a pending request.
module dtl_prio_pick
  import disk_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  output logic [1:0]   idx,
  output logic         vld
);

  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = 2'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/disk_track_loader.sv
// Streams whole tracks from the HPS block device into per-drive track RAM.
// Optional write-back of dirty tracks is enabled with TRACK_WRITEBACK_EN.
module disk_track_loader
  import disk_pkg::*;
#(
  parameter int DRIVES         = 2,
  parameter int SECS_PER_TRACK = NIB_SECS_PER_TRACK,
  parameter int TRACK_BITS     = 6,
  parameter int SEC_BITS       = 4
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic [DRIVES*TRACK_BITS-1:0] track,
  input  logic [DRIVES-1:0]            img_mounted,
  input  logic [DRIVES-1:0]            img_present,
  input  logic [DRIVES-1:0]            track_dirty,
  input  logic                         sd_ack,
  output logic [31:0]                  sd_lba,
  output logic [DRIVES-1:0]            sd_rd,
  output logic [DRIVES-1:0]            sd_wr,
  output logic [1:0]                   act_drive,
  output logic [SEC_BITS-1:0]          track_sec,
  output logic                         cpu_wait,
  output logic [DRIVES-1:0]            dirty_clr
);

  localparam logic [SEC_BITS-1:0] LAST_SEC = SEC_BITS'(SECS_PER_TRACK - 1);

  dtl_state_e                state_q, state_d;
  logic [31:0]               sd_lba_q, sd_lba_d;
  logic [DRIVES-1:0]         sd_rd_q, sd_rd_d;
  logic [DRIVES-1:0]         wr_req_q, wr_req_d;
  logic [DRIVES-1:0]         dirty_clr_q, dirty_clr_d;
  logic [1:0]                act_drive_q, act_drive_d;
  logic [SEC_BITS-1:0]       track_sec_q, track_sec_d;
  logic                      cpu_wait_q, cpu_wait_d;
  logic [TRACK_BITS-1:0]     load_track_q, load_track_d;
  logic                      ack_dly_q;
  logic [TRACK_BITS-1:0]     cur_track_q [DRIVES];
  logic [TRACK_BITS-1:0]     cur_track_d [DRIVES];
  logic [DRIVES-1:0]         valid_q, valid_d, pend_q, pend_d;

  logic                      ack_rise, ack_fall, load_done;
  logic [1:0]                pick_idx;
  logic                      pick_vld;
  logic [TRACK_BITS-1:0]     pick_trk, pick_cur, act_trk;
  logic                      pick_valid, pick_dirty;
  logic [DRIVES-1:0]         pick_mask, act_mask;

`ifdef TRACK_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
  assign sd_wr     = wr_req_q;
  assign dirty_clr = dirty_clr_q;
`else
  localparam bit WB_EN = 1'b0;
  logic unused_wb;
  assign sd_wr     = '0;
  assign dirty_clr = '0;
  assign unused_wb = ^{wr_req_q, dirty_clr_q};
`endif

  assign ack_rise  = sd_ack & ~ack_dly_q;
  assign ack_fall  = ~sd_ack & ack_dly_q;
  assign sd_lba    = sd_lba_q;
  assign sd_rd     = sd_rd_q;
  assign act_drive = act_drive_q;
  assign track_sec = track_sec_q;
  assign cpu_wait  = cpu_wait_q;

  dtl_prio_pick #(.N(DRIVES)) u_pick (
    .req (pend_q),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  always_comb begin
    pick_trk   = '0;
    pick_cur   = '0;
    pick_valid = 1'b0;
    pick_dirty = 1'b0;
    pick_mask  = '0;
    act_trk    = '0;
    act_mask   = '0;
    for (int i = 0; i < DRIVES; i++) begin
      if (2'(i) == pick_idx) begin
        pick_trk     = track[i*TRACK_BITS +: TRACK_BITS];
        pick_cur     = cur_track_q[i];
        pick_valid   = valid_q[i];
        pick_dirty   = track_dirty[i];
        pick_mask[i] = 1'b1;
      end
      if (2'(i) == act_drive_q) begin
        act_trk     = track[i*TRACK_BITS +: TRACK_BITS];
        act_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sd_lba_d     = sd_lba_q;
    sd_rd_d      = sd_rd_q;
    wr_req_d     = wr_req_q;
    dirty_clr_d  = '0;
    act_drive_d  = act_drive_q;
    track_sec_d  = track_sec_q;
    cpu_wait_d   = cpu_wait_q;
    load_track_d = load_track_q;
    load_done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          act_drive_d = pick_idx;
          track_sec_d = '0;
          cpu_wait_d  = 1'b1;
          if (WB_EN && pick_valid && pick_dirty) begin
            state_d  = ST_FLUSH;
            sd_lba_d = lba_of_track(32'(pick_cur), SECS_PER_TRACK);
            wr_req_d = pick_mask;
          end else begin
            state_d      = ST_LOAD;
            sd_lba_d     = lba_of_track(32'(pick_trk), SECS_PER_TRACK);
            load_track_d = pick_trk;
            sd_rd_d      = pick_mask;
          end
        end
      end
      default: begin
        if (ack_rise) begin
          sd_lba_d = sd_lba_q + 32'd1;
          if (track_sec_q == LAST_SEC) begin
            sd_rd_d  = '0;
            wr_req_d = '0;
          end
        end
        if (ack_fall) begin
          if (track_sec_q == LAST_SEC) begin
            track_sec_d = '0;
            if (state_q == ST_FLUSH) begin
              // Write-back finished: chain straight into the load of the new track.
              dirty_clr_d  = act_mask;
              sd_lba_d     = lba_of_track(32'(act_trk), SECS_PER_TRACK);
              load_track_d = act_trk;
              sd_rd_d      = act_mask;
              state_d      = ST_LOAD;
            end else begin
              load_done  = 1'b1;
              cpu_wait_d = 1'b0;
              state_d    = ST_IDLE;
            end
          end else begin
            track_sec_d = track_sec_q + SEC_BITS'(1);
          end
        end
      end
    endcase
  end

  for (genvar gi = 0; gi < DRIVES; gi++) begin : g_drive
    logic [TRACK_BITS-1:0] trk;
    logic                  done_here;
    assign trk       = track[gi*TRACK_BITS +: TRACK_BITS];
    assign done_here = load_done && (act_drive_q == 2'(gi));
    // A track move during the load keeps pend set so the drive reloads right away.
    assign pend_d[gi]  = !img_present[gi] ? 1'b0 :
                         img_mounted[gi]  ? 1'b1 :
                         done_here        ? (trk != load_track_q) :
                         (pend_q[gi] | ~valid_q[gi] | (trk != cur_track_q[gi]));
    assign valid_d[gi] = !img_present[gi] ? 1'b0 :
                         img_mounted[gi]  ? 1'b0 :
                         done_here        ? 1'b1 : valid_q[gi];
    assign cur_track_d[gi] = done_here ? load_track_q : cur_track_q[gi];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sd_lba_q     <= '0;
      sd_rd_q      <= '0;
      wr_req_q     <= '0;
      dirty_clr_q  <= '0;
      act_drive_q  <= '0;
      track_sec_q  <= '0;
      cpu_wait_q   <= 1'b0;
      load_track_q <= '0;
      ack_dly_q    <= 1'b0;
      valid_q      <= '0;
      pend_q       <= '0;
    end else begin
      state_q      <= state_d;
      sd_lba_q     <= sd_lba_d;
      sd_rd_q      <= sd_rd_d;
      wr_req_q     <= wr_req_d;
      dirty_clr_q  <= dirty_clr_d;
      act_drive_q  <= act_drive_d;
      track_sec_q  <= track_sec_d;
      cpu_wait_q   <= cpu_wait_d;
      load_track_q <= load_track_d;
      ack_dly_q    <= sd_ack;
      valid_q      <= valid_d;
      pend_q       <= pend_d;
    end
    for (int i = 0; i < DRIVES; i++) begin
      cur_track_q[i] <= reset ? '0 : cur_track_d[i];
    end
  end

endmodule

// File: tb/tb_disk_track_loader.sv
// Scoreboard bench for disk_track_loader: a small HPS model acknowledges
// each sector request and checks it against the queued expected sectors.
module tb_disk_track_loader;

  localparam int DRIVES = 2;
  localparam int SPT    = 13;
  localparam int TB     = 6;
  localparam int SB     = 4;

  logic              clk_sys = 1'b0;
  logic              reset   = 1'b1;
  logic [TB-1:0]     trk0 = '0, trk1 = '0;
  logic [DRIVES*TB-1:0] track;
  logic [DRIVES-1:0] img_mounted = '0, img_present = '0, track_dirty = '0;
  logic              sd_ack = 1'b0;
  logic [31:0]       sd_lba;
  logic [DRIVES-1:0] sd_rd, sd_wr, dirty_clr;
  logic [1:0]        act_drive;
  logic [SB-1:0]     track_sec;
  logic              cpu_wait;

  assign track = {trk1, trk0};
  always #5 clk_sys = ~clk_sys;

  disk_track_loader #(
    .DRIVES(DRIVES), .SECS_PER_TRACK(SPT), .TRACK_BITS(TB), .SEC_BITS(SB)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .track(track), .img_mounted(img_mounted),
    .img_present(img_present), .track_dirty(track_dirty), .sd_ack(sd_ack),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .act_drive(act_drive),
    .track_sec(track_sec), .cpu_wait(cpu_wait), .dirty_clr(dirty_clr)
  );

  typedef struct {
    logic [31:0] lba;
    logic [1:0]  drv;
    logic        wr;
    logic [3:0]  sec;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push_track(input logic wr, input logic [1:0] drv, input int trk,
                            input int first, input int count);
    exp_t e;
    for (int s = first; s < first + count; s++) begin
      e.lba = 32'(trk * SPT + s);
      e.drv = drv;
      e.wr  = wr;
      e.sec = 4'(s);
      exp_q.push_back(e);
    end
  endtask

  task automatic serve_sector();
    exp_t e;
    int   waited = 0;
    logic [DRIVES-1:0] mask;
    logic last;
    while ((sd_rd | sd_wr) == '0 && waited < 100) begin
      step();
      waited++;
    end
    if ((sd_rd | sd_wr) == '0) begin
      check_eq("req_timeout", 32'(sd_rd | sd_wr), 32'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check_eq("sb_unexpected_req", 32'(exp_q.size()), 32'd1);
      return;
    end
    e    = exp_q.pop_front();
    mask = DRIVES'(1) << e.drv;
    last = (e.sec == 4'(SPT - 1));
    $display("sector %s drv=%0d lba=%0d sec=%0d (dut lba=%0d sec=%0d)",
             e.wr ? "WR" : "RD", e.drv, e.lba, e.sec, sd_lba, track_sec);
    check_eq("lba", sd_lba, e.lba);
    check_eq("sec", 32'(track_sec), 32'(e.sec));
    check_eq("drive", 32'(act_drive), 32'(e.drv));
    check_eq("rd_vec", 32'(sd_rd), e.wr ? 32'd0 : 32'(mask));
    check_eq("wr_vec", 32'(sd_wr), e.wr ? 32'(mask) : 32'd0);
    check_eq("cpu_wait_busy", 32'(cpu_wait), 32'd1);
    sd_ack = 1'b1;
    step();
    check_eq("lba_after_rise", sd_lba, e.lba + 32'd1);
    check_eq("req_after_rise", 32'(e.wr ? sd_wr : sd_rd), last ? 32'd0 : 32'(mask));
    step();
    sd_ack = 1'b0;
    step();
    check_eq("sec_after_fall", 32'(track_sec), last ? 32'd0 : 32'(e.sec) + 32'd1);
  endtask

  task automatic serve_n(input int n);
    for (int i = 0; i < n; i++) serve_sector();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_rd"}, 32'(sd_rd), 32'd0);
    check_eq({tag, "_wr"}, 32'(sd_wr), 32'd0);
    check_eq({tag, "_lba"}, sd_lba, 32'd0);
    check_eq({tag, "_sec"}, 32'(track_sec), 32'd0);
    check_eq({tag, "_wait"}, 32'(cpu_wait), 32'd0);
    check_eq({tag, "_drive"}, 32'(act_drive), 32'd0);
    check_eq({tag, "_dclr"}, 32'(dirty_clr), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (3) step();
    check_outputs_zero("reset");
    reset = 1'b0;

    // No image present: track motion and mounts must not trigger anything.
    for (int i = 0; i < 10; i++) begin
      trk0 = 6'(i * 3);
      trk1 = 6'(i);
      img_mounted = (i == 2) ? 2'b11 : 2'b00;
      step();
      img_mounted = '0;
      check_eq("absent_rd", 32'(sd_rd), 32'd0);
      check_eq("absent_wait", 32'(cpu_wait), 32'd0);
    end

    // Mount drive 0 on track 0, then seek to track 5.
    trk0 = 6'd0;
    img_present = 2'b01;
    img_mounted = 2'b01;
    step();
    img_mounted = '0;
    push_track(1'b0, 2'd0, 0, 0, SPT);
    serve_n(SPT);
    check_eq("mount_done_wait", 32'(cpu_wait), 32'd0);
    trk0 = 6'd5;
    push_track(1'b0, 2'd0, 5, 0, SPT);
    serve_n(SPT);
    check_eq("t5_done_wait", 32'(cpu_wait), 32'd0);
    check_eq("t5_done_sec", 32'(track_sec), 32'd0);
    check_eq("t5_done_rd", 32'(sd_rd), 32'd0);

    // Both drives pending together: drive 0 first, one idle cycle, then drive 1.
    trk0 = 6'd7;
    trk1 = 6'd2;
    img_present = 2'b11;
    push_track(1'b0, 2'd0, 7, 0, SPT);
    push_track(1'b0, 2'd1, 2, 0, SPT);
    serve_n(SPT);
    check_eq("prio_gap_rd", 32'(sd_rd), 32'd0);
    check_eq("prio_gap_wait", 32'(cpu_wait), 32'd0);
    step();
    check_eq("prio_d1_rd", 32'(sd_rd), 32'd2);
    check_eq("prio_d1_lba", sd_lba, 32'd26);
    check_eq("prio_d1_wait", 32'(cpu_wait), 32'd1);
    check_eq("prio_d1_drive", 32'(act_drive), 32'd1);
    serve_n(SPT);

    // Track moves 5 -> 6 in the middle of the load of track 5.
    trk0 = 6'd5;
    push_track(1'b0, 2'd0, 5, 0, SPT);
    serve_n(4);
    trk0 = 6'd6;
    push_track(1'b0, 2'd0, 6, 0, SPT);
    serve_n(SPT - 4);
    check_eq("midload_done_wait", 32'(cpu_wait), 32'd0);
    step();
    check_eq("midload_reload_rd", 32'(sd_rd), 32'd1);
    check_eq("midload_reload_lba", sd_lba, 32'd78);
    serve_n(SPT);

`ifdef TRACK_WRITEBACK_EN
    trk0 = 6'd3;
    push_track(1'b0, 2'd0, 3, 0, SPT);
    serve_n(SPT);
    track_dirty = 2'b01;
    trk0 = 6'd4;
    push_track(1'b1, 2'd0, 3, 0, SPT);
    push_track(1'b0, 2'd0, 4, 0, SPT);
    serve_n(SPT);
    check_eq("wb_dirty_clr", 32'(dirty_clr), 32'd1);
    check_eq("wb_load_rd", 32'(sd_rd), 32'd1);
    check_eq("wb_load_lba", sd_lba, 32'd52);
    check_eq("wb_load_wait", 32'(cpu_wait), 32'd1);
    track_dirty = '0;
    step();
    check_eq("wb_dirty_clr_pulse", 32'(dirty_clr), 32'd0);
    serve_n(SPT);
`else
    // Dirty flag is ignored without write-back: a plain load follows.
    track_dirty = 2'b01;
    trk0 = 6'd3;
    push_track(1'b0, 2'd0, 3, 0, SPT);
    serve_n(SPT);
    check_eq("nowb_dirty_clr", 32'(dirty_clr), 32'd0);
    track_dirty = '0;
`endif

    // Reset while sector 7 of track 9 is in flight.
    trk0 = 6'd9;
    push_track(1'b0, 2'd0, 9, 0, 7);
    serve_n(7);
    check_eq("rst_sec7_lba", sd_lba, 32'd124);
    check_eq("rst_sec7_sec", 32'(track_sec), 32'd7);
    sd_ack = 1'b1;
    step();
    reset  = 1'b1;
    sd_ack = 1'b0;
    step();
    check_outputs_zero("midrst");
    reset = 1'b0;
    push_track(1'b0, 2'd0, 9, 0, SPT);
    push_track(1'b0, 2'd1, 2, 0, SPT);
    serve_n(2 * SPT);
    check_eq("post_rst_wait", 32'(cpu_wait), 32'd0);

    // Images removed: no more activity whatever the tracks do.
    img_present = '0;
    for (int i = 0; i < 10; i++) begin
      trk0 = 6'(i + 20);
      trk1 = 6'(i + 30);
      step();
      check_eq("removed_rd", 32'(sd_rd | sd_wr), 32'd0);
      check_eq("removed_wait", 32'(cpu_wait), 32'd0);
    end

    check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
